// File: rtl/inst_mem_pkg.sv
// Shared types and reset values for the instruction memory fetch unit.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } fetch_state_e;

  localparam fetch_state_e StateReset = StIdle;
  localparam logic         FlagReset  = 1'b0;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port, no reset.
module inst_mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inst_mem_fetch.sv
// Writable instruction memory with PC and valid/ready fetch sequencer.
// Optional per-word even parity when INST_MEM_PARITY_EN is defined.
module inst_mem_fetch
  import inst_mem_pkg::*;
#(
  parameter int unsigned INST_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              done,
`ifdef INST_MEM_PARITY_EN
  output logic              par_err,
`endif
  output logic              wr_err
);

`ifdef INST_MEM_PARITY_EN
  localparam int unsigned MEM_W = INST_W + 1;
`else
  localparam int unsigned MEM_W = INST_W;
`endif

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              wr_err_q, wr_err_d;
  logic              have_data_q;
  logic              mem_we, rd_en, restart, advance;
  logic [MEM_W-1:0]  mem_wdata, rd_data;

`ifdef INST_MEM_PARITY_EN
  assign mem_wdata = {^wr_data, wr_data};
`else
  assign mem_wdata = wr_data;
`endif

  inst_mem_array #(
    .DATA_W(MEM_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_addr),
    .wdata(mem_wdata),
    .re   (rd_en),
    .raddr(pc_q),
    .rdata(rd_data)
  );

  assign advance = !inst_valid_q || inst_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    end_d        = end_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    wr_err_d     = 1'b0;
    mem_we       = 1'b0;
    rd_en        = 1'b0;
    restart      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        // Write takes effect at this edge, ahead of the first read of a new run.
        mem_we = wr_en;
        if (start) begin
          state_d = StFetch;
          pc_d    = start_addr;
          end_d   = end_addr;
          restart = 1'b1;
        end
      end
      StFetch: begin
        wr_err_d = wr_en;
        if (jump_en) begin
          // Redirect flushes the in-flight beat, stalled or not.
          pc_d         = jump_addr;
          inst_valid_d = 1'b0;
        end else if (advance) begin
          rd_en        = 1'b1;
          inst_valid_d = 1'b1;
          inst_pc_d    = pc_q;
          if (pc_q == end_q) begin
            state_d = StDrain;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (inst_valid_q && inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = StDone;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StateReset;
      pc_q         <= '0;
      end_q        <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= FlagReset;
      wr_err_q     <= FlagReset;
      have_data_q  <= FlagReset;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      end_q        <= end_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      wr_err_q     <= wr_err_d;
      if (rd_en) begin
        have_data_q <= 1'b1;
      end
    end
  end

  // The array has no reset, so the read register is masked until it has been loaded.
  assign inst       = have_data_q ? rd_data[INST_W-1:0] : '0;
  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;
  assign busy       = (state_q == StFetch);
  assign done       = (state_q == StDone);
  assign wr_err     = wr_err_q;

`ifdef INST_MEM_PARITY_EN
  logic par_bad, par_err_q;

  assign par_bad = inst_valid_q && (^rd_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= FlagReset;
    end else if (restart) begin
      par_err_q <= 1'b0;
    end else if (par_bad) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q || par_bad;
`else
  logic unused_restart;
  assign unused_restart = restart;
`endif

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch; parity steps run when INST_MEM_PARITY_EN is defined.
module tb_inst_mem_fetch;

  localparam int unsigned INST_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [INST_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [AW-1:0]     start_addr = '0;
  logic [AW-1:0]     end_addr = '0;
  logic              jump_en = 1'b0;
  logic [AW-1:0]     jump_addr = '0;
  logic              inst_ready = 1'b0;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic [AW-1:0]     inst_pc;
  logic              busy;
  logic              done;
  logic              wr_err;
`ifdef INST_MEM_PARITY_EN
  logic              par_err;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  inst_mem_fetch #(
    .INST_W(INST_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .inst_ready(inst_ready),
    .inst      (inst),
    .inst_valid(inst_valid),
    .inst_pc   (inst_pc),
    .busy      (busy),
    .done      (done),
`ifdef INST_MEM_PARITY_EN
    .par_err   (par_err),
`endif
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [7:0] ei, input logic [3:0] ep);
    chk({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, ".inst"}, {24'd0, inst}, {24'd0, ei});
    chk({tag, ".pc"}, {28'd0, inst_pc}, {28'd0, ep});
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] sa, input logic [3:0] ea);
    start = 1'b1;
    start_addr = sa;
    end_addr = ea;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] wrap_inst [4] = '{8'hA1, 8'hB2, 8'h24, 8'h74};
  logic [3:0] wrap_pc   [4] = '{4'd14, 4'd15, 4'd0, 4'd1};

  initial begin
    // Reset values
    #1;
    chk("rst.inst", {24'd0, inst}, 32'd0);
    chk("rst.valid", {31'd0, inst_valid}, 32'd0);
    chk("rst.pc", {28'd0, inst_pc}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.wr_err", {31'd0, wr_err}, 32'd0);
    #12 rst_n = 1'b1;
    tick();

    load(4'd0, 8'b00100100);
    load(4'd1, 8'b01110100);
    load(4'd2, 8'hC3);
    load(4'd5, 8'hD5);
    load(4'd6, 8'hE6);
    load(4'd7, 8'hF7);
    load(4'd14, 8'hA1);
    load(4'd15, 8'hB2);

    // Two-instruction program, decoder always ready
    inst_ready = 1'b1;
    do_start(4'd0, 4'd1);
    chk("t1.busy", {31'd0, busy}, 32'd1);
    chk("t1.valid0", {31'd0, inst_valid}, 32'd0);
    tick(); beat("t1.b0", 8'h24, 4'd0);
    tick(); beat("t1.b1", 8'h74, 4'd1);
    chk("t1.drain_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t1.done", {31'd0, done}, 32'd1);
    chk("t1.valid_end", {31'd0, inst_valid}, 32'd0);

    // Stall for 3 cycles on the first beat, then on the last
    inst_ready = 1'b0;
    do_start(4'd0, 4'd1);
    tick(); beat("t2.b0", 8'h24, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); beat("t2.stall", 8'h24, 4'd0);
    end
    inst_ready = 1'b1;
    tick(); beat("t2.b1", 8'h74, 4'd1);
    inst_ready = 1'b0;
    tick(); beat("t2.hold_last", 8'h74, 4'd1);
    chk("t2.not_done", {31'd0, done}, 32'd0);
    inst_ready = 1'b1;
    tick();
    chk("t2.done", {31'd0, done}, 32'd1);

    // PC wraps from 15 to 0
    do_start(4'd14, 4'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); beat("t3.wrap", wrap_inst[i], wrap_pc[i]);
    end
    tick();
    chk("t3.done", {31'd0, done}, 32'd1);

    // Jump during a stalled beat at pc 2
    do_start(4'd0, 4'd7);
    tick(); beat("t4.b0", 8'h24, 4'd0);
    tick(); beat("t4.b1", 8'h74, 4'd1);
    tick(); beat("t4.b2", 8'hC3, 4'd2);
    inst_ready = 1'b0;
    tick(); beat("t4.stall2", 8'hC3, 4'd2);
    jump_en = 1'b1;
    jump_addr = 4'd5;
    tick();
    chk("t4.flush", {31'd0, inst_valid}, 32'd0);
    chk("t4.busy", {31'd0, busy}, 32'd1);
    jump_en = 1'b0;
    tick(); beat("t4.b5", 8'hD5, 4'd5);
    inst_ready = 1'b1;
    tick(); beat("t4.b6", 8'hE6, 4'd6);
    tick(); beat("t4.b7", 8'hF7, 4'd7);
    tick();
    chk("t4.done", {31'd0, done}, 32'd1);

    // start_addr == end_addr issues exactly one beat
    do_start(4'd5, 4'd5);
    tick(); beat("t5.single", 8'hD5, 4'd5);
    chk("t5.busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t5.done", {31'd0, done}, 32'd1);
    chk("t5.valid", {31'd0, inst_valid}, 32'd0);

    // Write attempt during FETCH is dropped and flagged
    do_start(4'd0, 4'd1);
    wr_en = 1'b1;
    wr_addr = 4'd0;
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    chk("t6.wr_err", {31'd0, wr_err}, 32'd1);
    beat("t6.b0", 8'h24, 4'd0);
    tick();
    chk("t6.wr_err_pulse", {31'd0, wr_err}, 32'd0);
    beat("t6.b1", 8'h74, 4'd1);
    tick();
    chk("t6.done", {31'd0, done}, 32'd1);

    // Replay, then reset mid-fetch
    do_start(4'd0, 4'd1);
    tick(); beat("t7.replay", 8'h24, 4'd0);
    rst_n = 1'b0;
    #1;
    chk("t7.rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("t7.rst_inst", {24'd0, inst}, 32'd0);
    chk("t7.rst_pc", {28'd0, inst_pc}, 32'd0);
    chk("t7.rst_busy", {31'd0, busy}, 32'd0);
    chk("t7.rst_done", {31'd0, done}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    do_start(4'd0, 4'd1);
    tick(); beat("t7.after_b0", 8'h24, 4'd0);
    tick(); beat("t7.after_b1", 8'h74, 4'd1);
    tick();
    chk("t7.done", {31'd0, done}, 32'd1);

`ifdef INST_MEM_PARITY_EN
    chk("t8.par_clean", {31'd0, par_err}, 32'd0);
    dut.u_array.mem[1][INST_W] = ~dut.u_array.mem[1][INST_W];
    do_start(4'd0, 4'd1);
    tick(); beat("t8.b0", 8'h24, 4'd0);
    chk("t8.par_b0", {31'd0, par_err}, 32'd0);
    tick(); beat("t8.b1", 8'h74, 4'd1);
    chk("t8.par_b1", {31'd0, par_err}, 32'd1);
    tick();
    chk("t8.par_held", {31'd0, par_err}, 32'd1);
    chk("t8.done", {31'd0, done}, 32'd1);
    do_start(4'd0, 4'd1);
    chk("t8.par_cleared", {31'd0, par_err}, 32'd0);
    tick();
    chk("t8.par_b0_again", {31'd0, par_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
